// File: rtl/mix_columns_engine.sv
// AES (Inv)MixColumns engine: iterates COLS_PER_CYCLE columns per clock over a
// 128-bit state with a valid/ready handshake. Optional MIXCOL_SKIP_EN adds a pass-through input.

module mix_column (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] res
);
  logic [7:0] b    [4];
  logic [7:0] x2   [4];
  logic [7:0] x4   [4];
  logic [7:0] x8   [4];
  logic [7:0] prod [4][4];

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    res = '0;
    for (int k = 0; k < 4; k++) begin
      b[k]  = col[31-8*k -: 8];
      x2[k] = xt(b[k]);
      x4[k] = xt(x2[k]);
      x8[k] = xt(x4[k]);
      // prod[k][j]: byte k times circulant coefficient j of the first row
      prod[k][0] = inv ? (x8[k] ^ x4[k] ^ x2[k]) : x2[k];
      prod[k][1] = inv ? (x8[k] ^ x2[k] ^ b[k])  : (x2[k] ^ b[k]);
      prod[k][2] = inv ? (x8[k] ^ x4[k] ^ b[k])  : b[k];
      prod[k][3] = inv ? (x8[k] ^ b[k])          : b[k];
    end
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        res[31-8*r -: 8] = res[31-8*r -: 8] ^ prod[k][(k - r + 4) % 4];
  end
endmodule

module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
`ifdef MIXCOL_SKIP_EN
  input  logic         skip,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  state_t                             state, state_nxt;
  logic [1:0]                         cnt;
  logic [3:0][31:0]                   work, work_nxt;
  logic                               inv_q, skip_q;
  logic                               accept;
  logic [1:0]                         col_idx [COLS_PER_CYCLE];
  logic [COLS_PER_CYCLE-1:0][31:0]    sel, mixed;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = work;

  // work[3] holds column 0, so column c lives at work[~c]
  generate
    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
      assign col_idx[i] = cnt + 2'(i);
      assign sel[i]     = work[~col_idx[i]];
      mix_column u_mix (.col(sel[i]), .inv(inv_q), .res(mixed[i]));
    end
  endgenerate

  always_comb begin
    work_nxt = work;
    if (!skip_q)
      for (int i = 0; i < COLS_PER_CYCLE; i++)
        work_nxt[~col_idx[i]] = mixed[i];
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (cnt == LAST) state_nxt = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      inv_q <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      work  <= in_data;
      inv_q <= inv;
      cnt   <= '0;
    end else if (state == BUSY) begin
      work  <= work_nxt;
      cnt   <= cnt + STEP;
    end
  end

`ifdef MIXCOL_SKIP_EN
  always_ff @(posedge clk) begin
    if (rst)         skip_q <= 1'b0;
    else if (accept) skip_q <= skip;
  end
`else
  assign skip_q = 1'b0;
`endif
endmodule

// File: tb/tb_mix_columns_engine.sv
// Drives three engines (COLS_PER_CYCLE = 1, 2, 4) in lockstep with shared inputs
// and checks each against hand-computed vectors and its own latency.

module tb_mix_columns_engine;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [2:0]   in_ready, out_valid;
  logic [127:0] out_data [3];
`ifdef MIXCOL_SKIP_EN
  logic         skip = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
    string        name;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
        .in_data(in_data), .inv(inv),
`ifdef MIXCOL_SKIP_EN
        .skip(skip),
`endif
        .out_valid(out_valid[g]), .out_ready(out_ready), .out_data(out_data[g]));
    end
  endgenerate

  task automatic chk(input string name, input int g, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cpc=%0d): got %h want %h", name, 1 << g, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic chk_zero);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk({tag, " out_valid"}, g, out_valid[g], 0);
      chk({tag, " in_ready"}, g, in_ready[g], 1);
      if (chk_zero) chk({tag, " out_data"}, g, out_data[g], '0);
    end
  endtask

  // called right after the accept edge; checks valid timing and result per engine
  task automatic wait_done(input logic [127:0] exp, input string tag);
    for (int k = 1; k <= 4; k++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        chk({tag, " out_valid"}, g, out_valid[g], (k >= (4 >> g)));
        if (k >= (4 >> g)) chk({tag, " out_data"}, g, out_data[g], exp);
      end
    end
  endtask

  task automatic accept_block(input logic inv_i, input logic [127:0] din, input string tag);
    in_valid = 1'b1;
    in_data  = din;
    inv      = inv_i;
    #1;
    for (int g = 0; g < 3; g++) chk({tag, " ready"}, g, in_ready[g], 1);
    tick();
    in_valid = 1'b0;
    in_data  = ~din;
    inv      = ~inv_i;
  endtask

  task automatic run_block(input logic inv_i, input logic [127:0] din, input logic [127:0] exp, input string tag);
    accept_block(inv_i, din, tag);
    wait_done(exp, tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle({tag, " drain"}, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c, "fips_fwd"};
    tbl[1] = '{1'b1, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, "fips_inv"};
    tbl[2] = '{1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, "cols_fwd"};
    tbl[3] = '{1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, "cols_inv"};
    tbl[4] = '{1'b0, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, "mix_fwd"};
    tbl[5] = '{1'b1, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, "mix_inv"};
    tbl[6] = '{1'b0, 128'h0, 128'h0, "zero_fwd"};
    tbl[7] = '{1'b1, {128{1'b1}}, {128{1'b1}}, "ones_inv"};

    tick();
    tick();
    check_idle("in_reset", 1'b1);
    rst = 1'b0;
    tick();
    check_idle("post_reset", 1'b1);

    for (int i = 0; i < 8; i++)
      run_block(tbl[i].inv, tbl[i].din, tbl[i].exp, tbl[i].name);

    // Stall in DONE, then handoff and new accept on the same edge
    accept_block(1'b0, tbl[0].din, "stall");
    wait_done(tbl[0].exp, "stall");
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        chk("stall hold data", g, out_data[g], tbl[0].exp);
        chk("stall hold valid", g, out_valid[g], 1);
        chk("stall in_ready", g, in_ready[g], 0);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = tbl[1].din;
    inv       = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chk("b2b in_ready", g, in_ready[g], 1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    inv       = 1'b0;
    for (int g = 0; g < 3; g++) chk("b2b busy valid", g, out_valid[g], 0);
    wait_done(tbl[1].exp, "b2b");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("b2b drain", 1'b0);

    // Reset in second BUSY cycle, colliding with accept/handoff requests
    accept_block(1'b0, tbl[2].din, "rst_mid");
    tick();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = tbl[4].din;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_idle("rst_mid", 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int g = 0; g < 3; g++) chk("rst_mid no stale", g, out_valid[g], 0);
    end

`ifdef MIXCOL_SKIP_EN
    skip = 1'b1;
    run_block(1'b0, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h00112233_44556677_8899aabb_ccddeeff, "skip");
    skip = 1'b0;
    run_block(tbl[0].inv, tbl[0].din, tbl[0].exp, "after_skip");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 Parameter: COLS_PER_CYCLE, default 1, number of state columns transformed per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 Port: clk  input  1  single clock for all state elements.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: in_valid  input  1  in_data/inv are valid.
REQ-005 Port: in_ready  output  1  engine accepts a block this cycle.
REQ-006 Port: in_data  input  128  AES state; column c = bits [127-32c -: 32], row 0 byte = most-significant byte of each column.
REQ-007 Port: inv  input  1  1 = InvMixColumns, 0 = forward MixColumns; sampled only at accept.
REQ-008 Port: out_valid  output  1  out_data holds a finished block.
REQ-009 Port: out_ready  input  1  downstream consumes the block this cycle.
REQ-010 Port: out_data  output  128  transformed state, same layout as in_data.

Function
REQ-011 Arithmetic SHALL be GF(2^8) with reduction polynomial 0x11B; the forward circulant row is {02,03,01,01} and the inverse row is {0E,0B,0D,09}, rotated right one byte per output row.
REQ-012 Block SHALL be an FSM with states IDLE, BUSY, DONE plus a column counter of width 2.
REQ-013 Accept occurs on a rising edge where in_valid && in_ready: in_data is loaded into the working register, inv is latched, counter = 0, state -> BUSY.
REQ-014 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-015 In BUSY, each edge SHALL replace columns counter .. counter+COLS_PER_CYCLE-1 with their transformed values and advance counter by COLS_PER_CYCLE.
REQ-016 After 4/COLS_PER_CYCLE BUSY edges, state -> DONE; out_valid SHALL be 1 in the cycle following the last BUSY edge (latency 4/COLS_PER_CYCLE cycles from accept edge to out_valid).
REQ-017 In DONE, out_data and out_valid SHALL hold stable until out_valid && out_ready.
REQ-018 If out_ready is 1 in DONE with in_valid 0, state -> IDLE and out_valid drops the next cycle.
REQ-019 If out_ready and in_valid are both 1 in DONE, handoff and new accept SHALL occur on the same edge (state -> BUSY, no bubble).
REQ-020 Inputs in_data/inv changing during BUSY/DONE SHALL have no effect.
REQ-021 out_data SHALL be driven from the working register; it is undefined-but-stable in BUSY and only meaningful while out_valid is 1.

Reset
REQ-022 On rst: state = IDLE, counter = 0, out_valid = 0, working register (out_data) = 0, latched inv = 0.
REQ-023 rst asserted during BUSY or DONE SHALL discard the block in progress, with no out_valid pulse afterwards.
REQ-024 rst SHALL take precedence over a simultaneous accept or handoff.

Configuration
REQ-025 Macro MIXCOL_SKIP_EN: when defined, an extra input port skip (1 bit, sampled at accept alongside inv) SHALL be present; a block accepted with skip=1 SHALL pass through unchanged with identical latency and handshake (AES final round).
REQ-026 Without MIXCOL_SKIP_EN, the skip port SHALL NOT exist and every block is transformed.

Verification
REQ-027 COLS_PER_CYCLE=1, inv=0, in_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_data=046681e5_e0cb199a_48f8d37a_2806264c, out_valid 4 cycles after accept.
REQ-028 COLS_PER_CYCLE=4, inv=1, in_data=046681e5_e0cb199a_48f8d37a_2806264c -> out_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5, out_valid 1 cycle after accept.
REQ-029 COLS_PER_CYCLE=2, inv=0, columns db135345, f20a225c, 01010101, c6c6c6c6 -> 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6, latency 2.
REQ-030 out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready 0; then out_ready=1 with in_valid=1 -> back-to-back accept on the same edge, next out_valid after 4/COLS_PER_CYCLE cycles.
REQ-031 rst pulsed on second BUSY cycle (COLS_PER_CYCLE=1) -> next cycle state IDLE, out_valid 0, out_data 0, in_ready 1, no stale output.
REQ-032 MIXCOL_SKIP_EN defined, skip=1, in_data=00112233_44556677_8899aabb_ccddeeff -> identical out_data after 4/COLS_PER_CYCLE cycles.
